// File: rtl/alien_march_scheduler_pkg.sv
// Shared game constants for the alien formation sequencing blocks.
package alien_march_scheduler_pkg;

    localparam int ALIEN_W          = 6;
    localparam int LEVEL_W          = 3;
    localparam int MAX_ALIENS       = 55;
    localparam int TICK_DIV_DEFAULT = 833333;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MARCH   = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_CLEARED = 3'd3,
        ST_OVER    = 3'd4
    } march_state_e;

    // Next wave level, saturating at max_level.
    function automatic logic [LEVEL_W-1:0] next_level(input logic [LEVEL_W-1:0] lvl,
                                                      input int max_level);
        if (int'(lvl) >= max_level)
            return lvl;
        else
            return lvl + 1'b1;
    endfunction

endpackage

// File: rtl/alien_march_scheduler_frame_tick_divider.sv
// Frame tick divider: free-running count of system clocks per frame, with
// a hold enable and synchronous clear. Tick is high on the last count.
module alien_march_scheduler_frame_tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic frame_tick_o
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    // Next divider value: wrap at the last count, hold when disabled.
    always_comb begin
        div_d = div_q;
        if (enable_i)
            div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
    end

    // Divider register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            div_q <= '0;
        else
            div_q <= div_d;
    end

    assign frame_tick_o = (div_q == LAST);

endmodule

// File: rtl/alien_march_scheduler.sv
// Alien march scheduler: wave-level game flow and the formation step strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | power-up, waiting for Start
// MARCH   | formation advancing, StepTick every Interval frames
// PAUSED  | frame divider and frame count frozen
// CLEARED | all aliens destroyed, Start begins next level
// OVER    | formation reached bottom, Start restarts at level 0
module alien_march_scheduler
    import alien_march_scheduler_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int MIN_FRAMES = 2,
    parameter int MAX_LEVEL  = 7
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic [ALIEN_W-1:0] aliens_alive_i,
    input  logic               reached_bottom_i,
    output logic               step_tick_o,
    output logic               formation_reset_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic               game_over_o,
    output logic [2:0]         state_o
);

    march_state_e       state_q, state_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               step_tick_q, step_tick_d;
    logic               formation_reset_q, formation_reset_d;
    logic               game_over_q, game_over_d;

    logic       frame_tick;
    logic       restart;
    logic       march_stay;
    logic       fire;
    logic [7:0] alive8, level8, min8, interval;

    // Restart happens whenever Start launches a wave from a non-marching state.
    assign restart    = (state_d == ST_MARCH) && (state_q != ST_MARCH) && (state_q != ST_PAUSED);
    assign march_stay = (state_q == ST_MARCH) && (state_d == ST_MARCH);

    alien_march_scheduler_frame_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_frame_div (
        .clk_i        (clk_i),
        .reset_i      (reset_i | restart),
        .enable_i     (state_q != ST_PAUSED),
        .frame_tick_o (frame_tick)
    );

    // Step interval in frames; the comparison comes first so the
    // subtraction can never wrap.
    always_comb begin
        alive8 = (int'(aliens_alive_i) > MAX_ALIENS) ? 8'(MAX_ALIENS)
                                                     : {{(8-ALIEN_W){1'b0}}, aliens_alive_i};
        level8 = {{(8-LEVEL_W){1'b0}}, level_q};
        min8   = 8'(MIN_FRAMES);
        if (alive8 > level8)
            interval = min8 + (alive8 - level8);
        else
            interval = min8;
    end

    // >= so that a shrinking interval fires on the very next frame tick.
    assign fire = frame_tick && (frame_cnt_q >= (interval - 8'd1));

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q           <= ST_IDLE;
            frame_cnt_q       <= '0;
            level_q           <= '0;
            step_tick_q       <= 1'b0;
            formation_reset_q <= 1'b0;
            game_over_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            frame_cnt_q       <= frame_cnt_d;
            level_q           <= level_d;
            step_tick_q       <= step_tick_d;
            formation_reset_q <= formation_reset_d;
            game_over_q       <= game_over_d;
        end
    end

    // Next-state logic; MARCH exits are prioritised bottom, cleared, pause.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_i) state_d = ST_MARCH;
            ST_MARCH: begin
                if (reached_bottom_i)         state_d = ST_OVER;
                else if (aliens_alive_i == '0) state_d = ST_CLEARED;
                else if (pause_i)              state_d = ST_PAUSED;
            end
            ST_PAUSED:  if (!pause_i) state_d = ST_MARCH;
            ST_CLEARED: if (start_i)  state_d = ST_MARCH;
            ST_OVER:    if (start_i)  state_d = ST_MARCH;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        step_tick_d       = march_stay && fire;
        formation_reset_d = restart;
        game_over_d       = (state_d == ST_OVER);
        frame_cnt_d       = frame_cnt_q;
        level_d           = level_q;

        if (restart) begin
            frame_cnt_d = '0;
        end else if (state_q == ST_MARCH && frame_tick) begin
            // On an exit cycle a due step is held back rather than lost.
            if (fire) begin
                if (march_stay)
                    frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end

        if (state_q == ST_CLEARED && start_i)
            level_d = next_level(level_q, MAX_LEVEL);
        else if (state_q == ST_OVER && start_i)
            level_d = '0;
    end

    assign step_tick_o       = step_tick_q;
    assign formation_reset_o = formation_reset_q;
    assign level_o           = level_q;
    assign game_over_o       = game_over_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_alien_march_scheduler.sv
// Directed bench for alien_march_scheduler with TICK_DIV=4, MIN_FRAMES=2.
module tb_alien_march_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pause;
    logic [5:0] aliens;
    logic       bottom;
    logic       step_tick;
    logic       freset;
    logic [2:0] level;
    logic       game_over;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    alien_march_scheduler #(
        .TICK_DIV   (4),
        .MIN_FRAMES (2),
        .MAX_LEVEL  (7)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .start_i           (start),
        .pause_i           (pause),
        .aliens_alive_i    (aliens),
        .reached_bottom_i  (bottom),
        .step_tick_o       (step_tick),
        .formation_reset_o (freset),
        .level_o           (level),
        .game_over_o       (game_over),
        .state_o           (state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Clocks until the next StepTick, bounded; -1 if none arrives.
    task automatic wait_step(output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            cyc();
            if (step_tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int pulses;

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; aliens = 6'd55; bottom = 1'b0;
        cyc(); cyc();
        chk("rst_state", 32'(state), 0);
        chk("rst_step", 32'(step_tick), 0);
        chk("rst_freset", 32'(freset), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_gameover", 32'(game_over), 0);

        // Start from IDLE, 55 aliens: interval 57 frames = 228 clocks.
        reset = 1'b0; start = 1'b1;
        cyc();
        chk("start_state", 32'(state), 1);
        chk("start_freset", 32'(freset), 1);
        start = 1'b0;
        cyc();
        chk("freset_one_cycle", 32'(freset), 0);
        wait_step(n);
        chk("first_step_latency", n, 227);
        wait_step(n);
        chk("period_55", n, 228);

        // Count to FrameCnt=10 (40 clocks) then drop to 3 aliens.
        repeat (40) cyc();
        aliens = 6'd3;
        wait_step(n);
        chk("shrink_fires_next_tick", n, 4);
        wait_step(n);
        chk("period_3", n, 20);

        // Pause 6 clocks after a step: 14 clocks remain to the next step.
        repeat (6) cyc();
        pause = 1'b1;
        cyc();
        chk("pause_state", 32'(state), 2);
        pulses = 0;
        for (int i = 0; i < 99; i++) begin
            cyc();
            if (step_tick === 1'b1) pulses++;
        end
        chk("pause_no_step", pulses, 0);
        pause = 1'b0;
        wait_step(n);
        chk("pause_resume_remaining", n, 14);
        chk("resume_state", 32'(state), 1);

        // Clear the wave, then climb levels to saturation.
        aliens = 6'd0;
        cyc();
        chk("cleared_state", 32'(state), 3);
        start = 1'b1;
        cyc();
        chk("clr_restart_state", 32'(state), 1);
        chk("clr_restart_level", 32'(level), 1);
        chk("clr_restart_freset", 32'(freset), 1);
        start = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            cyc();
            chk("reclear_state", 32'(state), 3);
            start = 1'b1;
            cyc();
            start = 1'b0;
            chk("level_climb", 32'(level), (k > 7) ? 7 : k);
        end
        // Level 7 with one alien: interval floors at 2 frames.
        aliens = 6'd1;
        wait_step(n);
        chk("floor_first_step", n, 8);
        wait_step(n);
        chk("floor_period", n, 8);

        // Bottom wins over cleared and pause.
        bottom = 1'b1; aliens = 6'd0; pause = 1'b1;
        cyc();
        chk("over_state", 32'(state), 4);
        chk("over_gameover", 32'(game_over), 1);
        chk("over_step", 32'(step_tick), 0);
        start = 1'b1;
        cyc();
        chk("over_restart_state", 32'(state), 1);
        chk("over_restart_level", 32'(level), 0);
        chk("over_restart_gameover", 32'(game_over), 0);
        chk("over_restart_freset", 32'(freset), 1);
        bottom = 1'b0; pause = 1'b0; start = 1'b0;

        // Reach level 5 through five clears.
        for (int k = 1; k <= 5; k++) begin
            cyc();
            start = 1'b1;
            cyc();
            start = 1'b0;
        end
        aliens = 6'd55;
        chk("level5_reached", 32'(level), 5);
        repeat (10) cyc();

        // Reset mid-MARCH with Start held across the release.
        reset = 1'b1; start = 1'b1;
        cyc();
        chk("midrst_state", 32'(state), 0);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_freset", 32'(freset), 0);
        chk("midrst_step", 32'(step_tick), 0);
        chk("midrst_gameover", 32'(game_over), 0);
        reset = 1'b0;
        cyc();
        chk("postrst_state", 32'(state), 1);
        chk("postrst_freset", 32'(freset), 1);
        start = 1'b0;
        cyc();
        wait_step(n);
        chk("postrst_first_step", n, 227);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alien_march_scheduler.md
Name: alien_march_scheduler

Overview:
- Sequences the alien formation. Produces the single-cycle step strobe that advances the formation position register by one horizontal step or one drop-down.
- Step rate rises as aliens are destroyed and as the wave level increases.
- Owns the wave-level game flow: idle, marching, paused, wave cleared, game over.
- Also produces the formation reset pulse, which restarts the formation at its home position.
- Sits between the top-level game FSM/inputs and the formation position block; its StepTick output is that block's advance enable.

Parameters:
- TICK_DIV, 833333: system clocks per frame tick (60 Hz at 50 MHz); simulation uses 4.
- MIN_FRAMES, 2: floor on the step interval, in frames.
- MAX_LEVEL, 7: level saturation value.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- Start  in  1  level, sampled each cycle; begins or restarts a wave.
- Pause  in  1  level; holds marching while high.
- AliensAlive  in  6  count of live aliens, 0..55.
- Reached_Bottom  in  1  level from the formation block.
- StepTick  out  1  one-cycle strobe that advances the formation.
- FormationReset  out  1  one-cycle strobe that resets the formation to home.
- Level  out  3  current wave level.
- GameOver  out  1  high while in OVER.
- State  out  3  encoded FSM state, for the HUD and debug.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: State=IDLE(0), StepTick=0, FormationReset=0, Level=0, GameOver=0, FrameDiv=0, FrameCnt=0. A Reset mid-wave takes effect on the next edge and overrides every other input.
- Frame divider: FrameDiv counts 0..TICK_DIV-1 in every state except PAUSED, where it holds. FrameTick is high internally for the one cycle in which FrameDiv = TICK_DIV-1.
- Interval (8-bit, combinational, every cycle): raw = MIN_FRAMES + AliensAlive - Level.
  - Interval = max(raw, MIN_FRAMES).
  - No underflow is permitted: compute the subtraction in 8 bits after the comparison.
- Step generation, MARCH state only:
  - On a FrameTick cycle with FrameCnt >= Interval-1, StepTick=1 for that cycle and FrameCnt returns to 0.
  - On other FrameTick cycles, FrameCnt increments.
  - The >= comparison means a shrinking Interval fires on the next FrameTick.
- State encoding: IDLE=0, MARCH=1, PAUSED=2, CLEARED=3, OVER=4.
- IDLE: Start=1 moves to MARCH. FormationReset pulses on the transition cycle and FrameCnt/FrameDiv clear.
- MARCH: conditions are checked in priority order, highest first.
  - Reached_Bottom=1 moves to OVER.
  - Otherwise AliensAlive=0 moves to CLEARED.
  - Otherwise Pause=1 moves to PAUSED.
  - StepTick is forced to 0 on any cycle in which MARCH exits.
- PAUSED:
  - FrameDiv and FrameCnt hold, and StepTick=0.
  - Pause=0 returns to MARCH, resuming the count exactly where it stopped.
  - Reached_Bottom and AliensAlive are ignored while paused.
- CLEARED: Start=1 moves to MARCH with Level = min(Level+1, MAX_LEVEL). FormationReset pulses and the counters clear.
- OVER:
  - GameOver=1.
  - Start=1 moves to MARCH with Level=0. FormationReset pulses and the counters clear.
- Start held high: only the IDLE/CLEARED/OVER edges act on it. In MARCH it has no effect, so a held Start does not retrigger.
- Outputs: all outputs are registered, so strobes appear one cycle after the deciding edge condition.

Decomposition:
- Shared game package holds:
  - state encoding constants (IDLE..OVER);
  - MAX_ALIENS=55;
  - the default TICK_DIV;
  - the alien-count width (6) and level width (3).
- One sub-module is natural: frame_tick_divider. It takes TICK_DIV, an enable input and sync reset, and outputs FrameTick. The playfield renderer can reuse it.
- Interval arithmetic and the FSM remain in this block.

Test Plan (TICK_DIV=4, MIN_FRAMES=2):
- Reset, then a 1-cycle Start with AliensAlive=55, Level=0: FormationReset is 1 for exactly one cycle, State=1, and StepTick pulses every 57 frames = 228 clocks.
- AliensAlive dropped from 55 to 3 mid-interval, with FrameCnt=10: StepTick fires on the next FrameTick; afterwards the period is 5 frames = 20 clocks.
- Pause high for 100 clocks mid-interval: State=2, no StepTick; after Pause drops, the remaining clocks-to-step equal the value before the pause.
- AliensAlive=0 in MARCH, then Start: State=3, then 1, Level=1, FormationReset pulses. Repeated clears saturate Level at 7. With AliensAlive=1 the interval floors at 2 frames.
- Reached_Bottom=1 asserted together with AliensAlive=0 and Pause=1: State=4 and GameOver=1; then Start gives Level=0 and State=1.
- Reset asserted mid-MARCH with Level=5: after the next edge all outputs are 0 and State=0; a Start held high across the Reset release enters MARCH on the first post-reset edge.
